// File: rtl/reverse_sequence_st_if.sv
// reverse_sequence_st_if
// Groups the two ready/valid streams of the record reverser and its overflow
// status into one bundle.
//   in_ready  : reverser can take a byte this cycle
//   in_valid  : upstream byte valid
//   in_data   : upstream base code
//   out_ready : downstream accepts the output byte
//   out_valid : output byte valid
//   out_data  : output byte
//   overflow  : one-cycle pulse when a chunk is force-flushed
// The slave modport is the reverser itself; the master modport is whatever
// feeds and drains it.
interface reverse_sequence_st_if;
    logic       in_ready;
    logic       in_valid;
    logic [0:7] in_data;
    logic       out_ready;
    logic       out_valid;
    logic [0:7] out_data;
    logic       overflow;

    modport slave (
        output in_ready,
        input  in_valid,
        input  in_data,
        input  out_ready,
        output out_valid,
        output out_data,
        output overflow
    );

    modport master (
        input  in_ready,
        output in_valid,
        output in_data,
        output out_ready,
        input  out_valid,
        input  out_data,
        input  overflow
    );
endinterface

// File: rtl/reverse_sequence_st.sv
// reverse_sequence_st
// Buffers one terminator-delimited record of base codes, then replays it in
// reverse order followed by the terminator. Placed after the complement stage
// this yields a reverse complement. Records longer than DEPTH are cut into
// DEPTH-sized chunks; each full chunk is flushed without a terminator and
// flagged with a one-cycle overflow pulse.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : reverse_sequence_st_if.slave (in/out ready-valid streams, overflow)
// All outputs are registered; there is no combinational input-to-output path.
module reverse_sequence_st #(
    parameter int         ADDR_WIDTH = 8,
    parameter int         DEPTH      = 2 ** ADDR_WIDTH,
    parameter logic [7:0] TERMINATOR = 8'h0A
) (
    input logic                  clock,
    input logic                  reset,
    reverse_sequence_st_if.slave bus
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    typedef enum logic [1:0] {
        FILL,
        DRAIN,
        TERM
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    logic            term_pending;
    logic            term_pending_next;
    logic            in_ready_q;
    logic            out_valid_q;
    logic            out_valid_next;
    logic [0:7]      out_data_q;
    logic [0:7]      out_data_next;
    logic            overflow_q;
    logic            overflow_next;
    logic            wr_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic            load_slot;
    logic            in_fire;

    logic [0:7] mem [DEPTH];

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.overflow  = overflow_q;

    // The output register may be (re)loaded when it is empty or being taken.
    // The newest stored byte sits at count-1, so draining from the top of the
    // buffer gives the reverse order for free.
    assign load_slot = !out_valid_q || bus.out_ready;
    assign in_fire   = in_ready_q && bus.in_valid;
    assign rd_addr   = count[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);

    // Next-state and next-output logic. FILL only accepts input, DRAIN only
    // emits stored bytes, TERM emits the delimiter; the record is processed
    // half-duplex so input and output never compete for the buffer.
    always_comb begin
        state_next        = state;
        count_next        = count;
        term_pending_next = term_pending;
        out_valid_next    = out_valid_q;
        out_data_next     = out_data_q;
        overflow_next     = 1'b0;
        wr_en             = 1'b0;

        case (state)
            FILL: begin
                if (out_valid_q && bus.out_ready) begin
                    out_valid_next = 1'b0;
                end
                if (in_fire) begin
                    if (bus.in_data == TERMINATOR) begin
                        if (count != '0) begin
                            state_next        = DRAIN;
                            term_pending_next = 1'b1;
                        end else begin
                            state_next = TERM;
                        end
                    end else begin
                        wr_en      = 1'b1;
                        count_next = count + ONE_C;
                        // A full buffer is flushed as a chunk with no
                        // delimiter; the rest of the record follows later.
                        if (count_next == DEPTH_C) begin
                            state_next        = DRAIN;
                            term_pending_next = 1'b0;
                            overflow_next     = 1'b1;
                        end
                    end
                end
            end

            DRAIN: begin
                if (load_slot) begin
                    out_data_next  = mem[rd_addr];
                    out_valid_next = 1'b1;
                    count_next     = count - ONE_C;
                    if (count == ONE_C) begin
                        state_next = term_pending ? TERM : FILL;
                    end
                end
            end

            TERM: begin
                if (load_slot) begin
                    out_data_next     = TERMINATOR;
                    out_valid_next    = 1'b1;
                    term_pending_next = 1'b0;
                    state_next        = FILL;
                end
            end

            default: begin
                state_next = FILL;
            end
        endcase
    end

    // Control and output registers. in_ready is registered from the next
    // state so it is already low in the cycle after a terminator or a
    // buffer-filling base is accepted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= FILL;
            count        <= '0;
            term_pending <= 1'b0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state        <= state_next;
            count        <= count_next;
            term_pending <= term_pending_next;
            in_ready_q   <= (state_next == FILL);
            out_valid_q  <= out_valid_next;
            out_data_q   <= out_data_next;
            overflow_q   <= overflow_next;
        end
    end

    // Record storage. It needs no reset: the occupancy counter decides which
    // entries are meaningful, so stale contents are never read.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[count[ADDR_WIDTH-1:0]] <= bus.in_data;
        end
    end

endmodule

// File: tb/tb_reverse_sequence_st.sv
// tb_reverse_sequence_st
// Scoreboard bench for reverse_sequence_st. Instance A uses the default
// 256-entry buffer, instance B a 4-entry buffer to exercise chunk overflow.
// Stimulus tasks push the hand-computed reversed bytes into a per-instance
// queue; independent monitors pop and compare whenever a byte is presented.
module tb_reverse_sequence_st;

    logic clock;
    logic reset;

    reverse_sequence_st_if if_a ();
    reverse_sequence_st_if if_b ();

    reverse_sequence_st dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (if_a)
    );

    reverse_sequence_st #(
        .ADDR_WIDTH (2)
    ) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (if_b)
    );

    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    int passCount  = 0;
    int checkCount = 0;
    int ovf_a      = 0;
    int ovf_b      = 0;
    int popped_a   = 0;

    // Free-running clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Monitor for instance A: compares each transferred byte against the
    // scoreboard head, and a stalled byte against the same head.
    always @(negedge clock) begin
        if (!reset) begin
            if (if_a.overflow) ovf_a++;
            if (if_a.out_valid) begin
                if (q_a.size() == 0) begin
                    checkCount++;
                    $display("[TB] FAIL a_unexpected_output: got %02h, expected no byte", if_a.out_data);
                end else if (if_a.out_ready) begin
                    checkOutput("a_out_data", 32'(if_a.out_data), 32'(q_a.pop_front()));
                    popped_a++;
                end else begin
                    checkOutput("a_stall_hold", 32'(if_a.out_data), 32'(q_a[0]));
                end
            end
        end
    end

    // Monitor for instance B, same scheme.
    always @(negedge clock) begin
        if (!reset) begin
            if (if_b.overflow) ovf_b++;
            if (if_b.out_valid) begin
                if (q_b.size() == 0) begin
                    checkCount++;
                    $display("[TB] FAIL b_unexpected_output: got %02h, expected no byte", if_b.out_data);
                end else if (if_b.out_ready) begin
                    checkOutput("b_out_data", 32'(if_b.out_data), 32'(q_b.pop_front()));
                end else begin
                    checkOutput("b_stall_hold", 32'(if_b.out_data), 32'(q_b[0]));
                end
            end
        end
    end

    task automatic pushExp(input int sel, input logic [7:0] b);
        if (sel == 0) q_a.push_back(b);
        else          q_b.push_back(b);
    endtask

    // Presents one byte and returns at the negedge after it was accepted.
    task automatic applyStimulus(input int sel, input logic [7:0] b);
        logic accepted;
        logic done;
        int   guard;
        if (sel == 0) begin
            if_a.in_valid = 1'b1;
            if_a.in_data  = b;
        end else begin
            if_b.in_valid = 1'b1;
            if_b.in_data  = b;
        end
        done  = 1'b0;
        guard = 0;
        while (!done) begin
            accepted = (sel == 0) ? if_a.in_ready : if_b.in_ready;
            @(posedge clock);
            @(negedge clock);
            guard++;
            if (accepted) begin
                done = 1'b1;
            end else if (guard > 200) begin
                checkCount++;
                $display("[TB] FAIL accept_timeout: byte %02h not accepted after %0d cycles", b, guard);
                done = 1'b1;
            end
        end
    endtask

    task automatic idle(input int sel);
        if (sel == 0) if_a.in_valid = 1'b0;
        else          if_b.in_valid = 1'b0;
    endtask

    // Sends s followed by the terminator; the expected reversed record is
    // queued first.
    task automatic sendRecord(input int sel, input string s);
        for (int i = s.len() - 1; i >= 0; i--) pushExp(sel, s[i]);
        pushExp(sel, 8'h0A);
        for (int i = 0; i < s.len(); i++) applyStimulus(sel, s[i]);
        applyStimulus(sel, 8'h0A);
    endtask

    task automatic waitDrain(input int sel, input string name);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clock);
            if (sel == 0) done = (q_a.size() == 0) && !if_a.out_valid;
            else          done = (q_b.size() == 0) && !if_b.out_valid;
        end
        checkOutput(name, 32'(done), 32'd1);
    endtask

    // Directed test sequence.
    initial begin
        int lowCnt;
        int validCnt;
        int target;
        logic reached;

        reset          = 1'b1;
        if_a.in_valid  = 1'b0;
        if_a.in_data   = '0;
        if_a.out_ready = 1'b1;
        if_b.in_valid  = 1'b0;
        if_b.in_data   = '0;
        if_b.out_ready = 1'b1;

        repeat (2) @(negedge clock);
        checkOutput("a_rst_in_ready",  32'(if_a.in_ready),  32'd1);
        checkOutput("a_rst_out_valid", 32'(if_a.out_valid), 32'd0);
        checkOutput("a_rst_out_data",  32'(if_a.out_data),  32'd0);
        checkOutput("a_rst_overflow",  32'(if_a.overflow),  32'd0);
        checkOutput("b_rst_in_ready",  32'(if_b.in_ready),  32'd1);
        checkOutput("b_rst_out_valid", 32'(if_b.out_valid), 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);

        // ACGT: 54 47 43 41 0A back to back, in_ready low for 5 cycles.
        $display("[TB] record ACGT");
        sendRecord(0, "ACGT");
        idle(0);
        lowCnt   = 0;
        validCnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (!if_a.in_ready) lowCnt++;
            if (if_a.out_valid) validCnt++;
            @(negedge clock);
        end
        checkOutput("acgt_in_ready_low_cycles", 32'(lowCnt), 32'd5);
        checkOutput("acgt_valid_cycles", 32'(validCnt), 32'd5);
        waitDrain(0, "acgt_drained");

        // Lone terminator: just 0A one cycle later.
        $display("[TB] lone terminator");
        sendRecord(0, "");
        idle(0);
        checkOutput("lone_in_ready_low", 32'(if_a.in_ready), 32'd0);
        checkOutput("lone_no_early_out", 32'(if_a.out_valid), 32'd0);
        @(negedge clock);
        checkOutput("lone_term_valid", 32'(if_a.out_valid), 32'd1);
        checkOutput("lone_in_ready_back", 32'(if_a.in_ready), 32'd1);
        waitDrain(0, "lone_drained");
        checkOutput("lone_no_overflow", 32'(ovf_a), 32'd0);

        // GATTACA with downstream toggling every cycle.
        $display("[TB] record GATTACA with backpressure");
        sendRecord(0, "GATTACA");
        idle(0);
        repeat (30) begin
            @(posedge clock);
            #1 if_a.out_ready = ~if_a.out_ready;
        end
        if_a.out_ready = 1'b1;
        waitDrain(0, "gattaca_drained");

        // DEPTH=4 instance: ACGTA splits into a flushed chunk and a record.
        $display("[TB] overflow chunk on 4-entry buffer");
        pushExp(1, 8'h54);
        pushExp(1, 8'h47);
        pushExp(1, 8'h43);
        pushExp(1, 8'h41);
        pushExp(1, 8'h41);
        pushExp(1, 8'h0A);
        applyStimulus(1, 8'h41);
        applyStimulus(1, 8'h43);
        applyStimulus(1, 8'h47);
        applyStimulus(1, 8'h54);
        checkOutput("b_overflow_pulse", 32'(if_b.overflow), 32'd1);
        applyStimulus(1, 8'h41);
        applyStimulus(1, 8'h0A);
        idle(1);
        waitDrain(1, "b_drained");
        checkOutput("b_overflow_count", 32'(ovf_b), 32'd1);

        // Back-to-back records with in_valid held high.
        $display("[TB] back-to-back AC GT");
        sendRecord(0, "AC");
        sendRecord(0, "GT");
        idle(0);
        waitDrain(0, "b2b_drained");

        // Reset in the middle of draining ACGT.
        $display("[TB] reset mid-drain");
        sendRecord(0, "ACGT");
        idle(0);
        target  = popped_a + 2;
        reached = 1'b0;
        for (int i = 0; i < 100 && !reached; i++) begin
            @(posedge clock);
            #2 reached = (popped_a >= target);
        end
        checkOutput("mid_drain_reached", 32'(reached), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_in_ready",  32'(if_a.in_ready),  32'd1);
        checkOutput("mid_rst_out_valid", 32'(if_a.out_valid), 32'd0);
        checkOutput("mid_rst_out_data",  32'(if_a.out_data),  32'd0);
        checkOutput("mid_rst_overflow",  32'(if_a.overflow),  32'd0);
        q_a.delete();
        repeat (2) @(negedge clock);
        @(posedge clock);
        #1 reset = 1'b0;
        repeat (3) begin
            @(negedge clock);
            checkOutput("no_emit_after_reset", 32'(if_a.out_valid), 32'd0);
        end
        sendRecord(0, "T");
        idle(0);
        waitDrain(0, "post_reset_drained");

        checkOutput("a_queue_empty", 32'(q_a.size()), 32'd0);
        checkOutput("b_queue_empty", 32'(q_b.size()), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
